fm_wm_dot_product_engine: RTL and testbench
===========================================

Name: fm_wm_dot_product_engine

Overview:
Compute engine directly upstream of the FM×WM product memory. On a start pulse it walks every (feature row, weight column) pair and accumulates one element product per cycle over the shared dimension. Each finished dot product is presented on write_row / write_col / fm_wm_out, which drive the memory's write port directly. Feature and weight operands come from external element-addressed memories with combinational reads.

Parameters:
FEATURE_ROWS, 6, rows of feature matrix (= rows of product memory)
FEATURE_COLS, 96, shared dimension (feature cols = weight rows)
WEIGHT_COLS, 3, columns of weight matrix (= cols of product memory)
DATA_WIDTH, 5, unsigned width of each feature/weight element
DOT_PROD_WIDTH, 16, accumulator and output width
FEATURE_WIDTH, $clog2(FEATURE_ROWS), row index width
WEIGHT_WIDTH, $clog2(WEIGHT_COLS), column index width
K_WIDTH, $clog2(FEATURE_COLS), shared-dimension index width

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
start  input  1  begin full matrix product; sampled only in IDLE
fm_row_idx  output  FEATURE_WIDTH  feature read row (= current row)
fm_col_idx  output  K_WIDTH  feature read col (= k)
fm_data  input  DATA_WIDTH  feature element, valid same cycle
wm_row_idx  output  K_WIDTH  weight read row (= k)
wm_col_idx  output  WEIGHT_WIDTH  weight read col (= current col)
wm_data  input  DATA_WIDTH  weight element, valid same cycle
write_row  output  FEATURE_WIDTH  product memory write row
write_col  output  WEIGHT_WIDTH  product memory write col
fm_wm_out  output  DOT_PROD_WIDTH  product memory write data
fm_wm_wr_en  output  1  one-cycle strobe marking a fresh result
busy  output  1  high in MAC/WRITE
done  output  1  one-cycle pulse after last write

Behaviour:
- Reset (async, any state): state=IDLE. Zeroed: row, col, k, acc, write_row, write_col, fm_wm_out, fm_wm_wr_en, busy, done.
- FSM states: IDLE, MAC, WRITE, DONE.
- IDLE: start=1 -> MAC with row=0, col=0, k=0, acc=0. Otherwise stay.
- MAC: each cycle acc <= acc + zero_ext(fm_data*wm_data). The product is 2*DATA_WIDTH bits; accumulation wraps mod 2^DOT_PROD_WIDTH.
  - k increments each cycle.
  - At k==FEATURE_COLS-1: accumulate, then go to WRITE.
- WRITE (1 cycle): register write_row<=row, write_col<=col, fm_wm_out<=final acc. fm_wm_wr_en is high for the cycle these registers hold the new value.
  - Then col++, k=0, acc=0.
  - If col==WEIGHT_COLS-1: col=0, row++.
  - After the pair (FEATURE_ROWS-1, WEIGHT_COLS-1) -> DONE; else -> MAC.
- DONE: done=1 for exactly one cycle -> IDLE.
- Write-hold rule: the product memory writes every clock with no enable. write_row, write_col and fm_wm_out are therefore registered and change only on a write update; they hold their last value otherwise, so repeated writes are idempotent.
- Write order: row-major (0,0),(0,1),(0,2),(1,0)…
- Index outputs are combinational from row/col/k. They are don't-care outside MAC but still driven from the registers.
- start while not IDLE: ignored, no restart.
- Latency: each element takes FEATURE_COLS+1 cycles. done rises FEATURE_ROWS*WEIGHT_COLS*(FEATURE_COLS+1)+1 cycles after the start-sampling edge (1747 at defaults).
- rst mid-operation: abort immediately, all state cleared. The product memory shares rst and clears too; a new start recomputes everything.

Optional Feature:
Macro FM_WM_SATURATE_EN.
- Defined: the accumulator saturates at 2^DOT_PROD_WIDTH-1 and stays there for the rest of that dot product. Saturation uses a DOT_PROD_WIDTH+1 bit intermediate sum.
- Undefined: plain modular wrap.
- Latency and interface are identical in both cases.

Test Plan:
1. Assert rst mid-idle and mid-MAC -> all outputs 0, busy=0, done=0 within the same cycle (async).
2. All fm=1, wm=1, start pulse -> 18 writes in row-major order, each fm_wm_out=96. wr_en is spaced 97 cycles apart; done pulses at cycle 1747.
3. fm[i][0]=i+1, wm[0][j]=j+1, all other elements 0 -> memory holds (i+1)*(j+1); e.g. (5,2)=18.
4. All fm=31, wm=31 -> sum 92256. Without macro fm_wm_out=26720 (wrap); with FM_WM_SATURATE_EN fm_wm_out=65535.
5. Pulse start again at cycle 300 of a run -> ignored, sequence unchanged. Assert rst at cycle 500 -> IDLE; fresh start gives the full correct result.
6. Monitor write_row/write_col/fm_wm_out on non-wr_en cycles -> unchanged from the previous write. Read back the product memory after done -> matches the golden model.

Source files
------------

// File: rtl/fm_wm_dot_product_engine.sv
// FM x WM dot-product engine: walks every (row, col) pair, one MAC per cycle over the shared dimension.
// Optional build macro FM_WM_SATURATE_EN makes the accumulator saturate instead of wrapping.
module fm_wm_dot_product_engine #(
    parameter int FEATURE_ROWS   = 6,
    parameter int FEATURE_COLS   = 96,
    parameter int WEIGHT_COLS    = 3,
    parameter int DATA_WIDTH     = 5,
    parameter int DOT_PROD_WIDTH = 16,
    parameter int FEATURE_WIDTH  = $clog2(FEATURE_ROWS),
    parameter int WEIGHT_WIDTH   = $clog2(WEIGHT_COLS),
    parameter int K_WIDTH        = $clog2(FEATURE_COLS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [FEATURE_WIDTH-1:0]  fm_row_idx,
    output logic [K_WIDTH-1:0]        fm_col_idx,
    input  logic [DATA_WIDTH-1:0]     fm_data,
    output logic [K_WIDTH-1:0]        wm_row_idx,
    output logic [WEIGHT_WIDTH-1:0]   wm_col_idx,
    input  logic [DATA_WIDTH-1:0]     wm_data,
    output logic [FEATURE_WIDTH-1:0]  write_row,
    output logic [WEIGHT_WIDTH-1:0]   write_col,
    output logic [DOT_PROD_WIDTH-1:0] fm_wm_out,
    output logic                      fm_wm_wr_en,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    state_t                    state, next_state;
    logic [FEATURE_WIDTH-1:0]  row;
    logic [WEIGHT_WIDTH-1:0]   col;
    logic [K_WIDTH-1:0]        k;
    logic [DOT_PROD_WIDTH-1:0] acc, acc_nxt;
    logic [2*DATA_WIDTH-1:0]   prod;
    logic                      last_k, last_col, last_row;

    assign last_k   = (k == K_WIDTH'(FEATURE_COLS - 1));
    assign last_col = (col == WEIGHT_WIDTH'(WEIGHT_COLS - 1));
    assign last_row = (row == FEATURE_WIDTH'(FEATURE_ROWS - 1));

    assign fm_row_idx = row;
    assign fm_col_idx = k;
    assign wm_row_idx = k;
    assign wm_col_idx = col;

    assign prod = {{DATA_WIDTH{1'b0}}, fm_data} * {{DATA_WIDTH{1'b0}}, wm_data};

`ifdef FM_WM_SATURATE_EN
    // Extra carry bit detects overflow; once pinned at max, non-negative products keep it there.
    logic [DOT_PROD_WIDTH:0] sum;
    assign sum     = {1'b0, acc} + (DOT_PROD_WIDTH + 1)'(prod);
    assign acc_nxt = sum[DOT_PROD_WIDTH] ? '1 : sum[DOT_PROD_WIDTH-1:0];
`else
    assign acc_nxt = acc + DOT_PROD_WIDTH'(prod);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = MAC;
            MAC:     if (last_k) next_state = WRITE;
            WRITE:   next_state = (last_row && last_col) ? DONE : MAC;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == MAC) || (state == WRITE);
    end

    // Write port registers only move on a WRITE cycle; the memory writes every clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row         <= '0;
            col         <= '0;
            k           <= '0;
            acc         <= '0;
            write_row   <= '0;
            write_col   <= '0;
            fm_wm_out   <= '0;
            fm_wm_wr_en <= 1'b0;
            done        <= 1'b0;
        end else begin
            fm_wm_wr_en <= (state == WRITE);
            done        <= (state == DONE);
            case (state)
                IDLE: if (start) begin
                    row <= '0;
                    col <= '0;
                    k   <= '0;
                    acc <= '0;
                end
                MAC: begin
                    acc <= acc_nxt;
                    k   <= last_k ? '0 : k + K_WIDTH'(1);
                end
                WRITE: begin
                    write_row <= row;
                    write_col <= col;
                    fm_wm_out <= acc;
                    k         <= '0;
                    acc       <= '0;
                    if (last_col) begin
                        col <= '0;
                        row <= last_row ? '0 : row + FEATURE_WIDTH'(1);
                    end else begin
                        col <= col + WEIGHT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fm_wm_dot_product_engine.sv
// Bench for fm_wm_dot_product_engine: table of operand patterns, golden model, write scoreboard.
module tb_fm_wm_dot_product_engine;

    localparam int FR = 6, FC = 96, WC = 3;
    localparam int LAT = FR * WC * (FC + 1) + 1;
`ifdef FM_WM_SATURATE_EN
    localparam int EXP31 = 65535;
`else
    localparam int EXP31 = 26720;
`endif

    logic        clk, rst, start;
    logic [2:0]  fm_row_idx, write_row;
    logic [6:0]  fm_col_idx, wm_row_idx;
    logic [1:0]  wm_col_idx, write_col;
    logic [4:0]  fm_data, wm_data;
    logic [15:0] fm_wm_out;
    logic        fm_wm_wr_en, busy, done;

    fm_wm_dot_product_engine dut (
        .clk(clk), .rst(rst), .start(start),
        .fm_row_idx(fm_row_idx), .fm_col_idx(fm_col_idx), .fm_data(fm_data),
        .wm_row_idx(wm_row_idx), .wm_col_idx(wm_col_idx), .wm_data(wm_data),
        .write_row(write_row), .write_col(write_col), .fm_wm_out(fm_wm_out),
        .fm_wm_wr_en(fm_wm_wr_en), .busy(busy), .done(done)
    );

    typedef struct { int r; int c; int v; } exp_t;
    typedef struct { int kind; int fv; int wv; int exp00; int exp52; } vec_t;

    logic [4:0]  fm_mem [FR][FC];
    logic [4:0]  wm_mem [FC][WC];
    logic [15:0] pm [FR][WC];
    int          gold [FR][WC];
    exp_t        q[$];
    int          tests = 0, fails = 0, cyc = 0;
    int          last_wr = -1;
    logic [2:0]  last_row = '0;
    logic [1:0]  last_col = '0;
    logic [15:0] last_out = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        fm_data = '0;
        wm_data = '0;
        if (int'(fm_row_idx) < FR && int'(fm_col_idx) < FC) fm_data = fm_mem[fm_row_idx][fm_col_idx];
        if (int'(wm_row_idx) < FC && int'(wm_col_idx) < WC) wm_data = wm_mem[wm_row_idx][wm_col_idx];
    end

    // Product memory: unconditional write every clock, shares rst.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < FR; r++) for (int c = 0; c < WC; c++) pm[r][c] <= '0;
        end else if (int'(write_row) < FR && int'(write_col) < WC) begin
            pm[write_row][write_col] <= fm_wm_out;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_row = '0; last_col = '0; last_out = '0; last_wr = -1;
        end else if (fm_wm_wr_en) begin
            if (q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = q.pop_front();
                check("wr_row", write_row, e.r);
                check("wr_col", write_col, e.c);
                check("wr_data", fm_wm_out, e.v);
            end
            if (last_wr >= 0) check("wr_spacing", cyc - last_wr, FC + 1);
            last_wr = cyc;
            last_row = write_row; last_col = write_col; last_out = fm_wm_out;
        end else begin
            check("write_hold", {write_row, write_col, fm_wm_out}, {last_row, last_col, last_out});
            if (!busy) last_wr = -1;
        end
    end

    task automatic load(input int kind, input int fv, input int wv);
        for (int i = 0; i < FR; i++)
            for (int k = 0; k < FC; k++)
                case (kind)
                    0:       fm_mem[i][k] = 5'(fv);
                    1:       fm_mem[i][k] = (k == 0) ? 5'(i + 1) : 5'd0;
                    default: fm_mem[i][k] = 5'($urandom_range(0, 31));
                endcase
        for (int k = 0; k < FC; k++)
            for (int j = 0; j < WC; j++)
                case (kind)
                    0:       wm_mem[k][j] = 5'(wv);
                    1:       wm_mem[k][j] = (k == 0) ? 5'(j + 1) : 5'd0;
                    default: wm_mem[k][j] = 5'($urandom_range(0, 31));
                endcase
        for (int r = 0; r < FR; r++)
            for (int c = 0; c < WC; c++) begin
                int a;
                a = 0;
                for (int k = 0; k < FC; k++) begin
                    a += int'(fm_mem[r][k]) * int'(wm_mem[k][c]);
`ifdef FM_WM_SATURATE_EN
                    if (a > 65535) a = 65535;
`endif
                end
                gold[r][c] = a % 65536;
                q.push_back('{r, c, a % 65536});
            end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic finish_run(input int exp00, input int exp52);
        int n;
        n = 0;
        while (!done && n < LAT + 200) begin
            @(posedge clk); #1 n++;
        end
        check("done_latency", n, LAT);
        @(posedge clk); #1;
        check("done_one_cycle", {done, busy}, 0);
        check("queue_drained", q.size(), 0);
        for (int r = 0; r < FR; r++)
            for (int c = 0; c < WC; c++) check("readback", pm[r][c], gold[r][c]);
        if (exp00 >= 0) check("corner00", pm[0][0], exp00);
        if (exp52 >= 0) check("corner52", pm[FR-1][WC-1], exp52);
    endtask

    task automatic check_cleared(input string name);
        check(name, {write_row, write_col, fm_wm_out, fm_wm_wr_en, busy, done}, 0);
        check({name, "_idx"}, {fm_row_idx, fm_col_idx, wm_col_idx}, 0);
    endtask

    initial begin
        vec_t vecs[6];
        int n;
        vecs[0] = '{0, 1, 1, 96, 96};
        vecs[1] = '{1, 0, 0, 1, 18};
        vecs[2] = '{0, 31, 31, EXP31, EXP31};
        vecs[3] = '{2, 0, 0, -1, -1};
        vecs[4] = '{0, 0, 0, 0, 0};
        vecs[5] = '{0, 31, 1, 2976, 2976};

        rst = 1'b0; start = 1'b0;
        #2 rst = 1'b1;
        #1 check_cleared("reset_state");
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            load(vecs[i].kind, vecs[i].fv, vecs[i].wv);
            pulse_start();
            finish_run(vecs[i].exp00, vecs[i].exp52);
        end

        // Async reset while idle with non-zero held outputs.
        @(posedge clk); #3 rst = 1'b1;
        #1 check_cleared("rst_idle");
        check("rst_idle_pm", pm[FR-1][WC-1], 0);
        @(posedge clk); #1 rst = 1'b0;

        // Async reset mid-MAC.
        load(0, 1, 1);
        pulse_start();
        repeat (150) @(posedge clk);
        #3 check("busy_mid_mac", busy, 1);
        rst = 1'b1;
        #1 check_cleared("rst_mac");
        q.delete();
        @(posedge clk); #1 rst = 1'b0;

        // start during a run is ignored; reset at cycle 500 aborts; fresh start recomputes.
        load(0, 2, 3);
        pulse_start();
        n = 1;
        while (n < 500) begin
            @(posedge clk); #1 n++;
            start = (n == 300);
        end
        start = 1'b0;
        check("busy_before_rst", busy, 1);
        rst = 1'b1;
        #1 check_cleared("rst_500");
        q.delete();
        @(posedge clk); #1 rst = 1'b0;
        load(0, 2, 3);
        pulse_start();
        finish_run(576, 576);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
